// File: rtl/gray_stream.sv
// gray_stream: streaming RGB-to-grey (average/luma/passthrough) with row/frame flags.
// Define GRAY_STATS_EN to build the per-frame Y accumulator driving frame_sum/frame_done.
module gray_stream #(
  parameter int DW = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [1:0]                          mode,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [3*DW-1:0]                     s_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [3*DW-1:0]                     m_data,
  output logic                                m_eol,
  output logic                                m_eof,
  output logic [DW+$clog2(IMG_W*IMG_H)-1:0]   frame_sum,
  output logic                                frame_done
);
  localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0] mode_q, cur_mode, s1_mode;
  logic s1_valid, s1_eol, s1_eof, s1_ld, s2_ld, in_xfer, first, eol, eof;
  logic [DW+1:0] s1_sum;
  logic [DW+7:0] s1_luma;
  logic [3*DW-1:0] s1_rgb;
  logic [DW-1:0] r, g, b, y;
  always_comb begin
    {r, g, b} = s_data;
    s2_ld = !m_valid || m_ready;
    s1_ld = !s1_valid || s2_ld;
    s_ready = s1_ld;
    in_xfer = s_valid && s1_ld;
    first = col == '0 && row == '0;
    cur_mode = first ? mode : mode_q;
    eol = col == CW'(IMG_W - 1);
    eof = eol && row == RW'(IMG_H - 1);
    y = s1_mode == 2'd1 ? DW'(s1_luma >> 8) : DW'(s1_sum / (DW+2)'(3));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_eol <= 1'b0;
      m_eof <= 1'b0;
      col <= '0;
      row <= '0;
      mode_q <= 2'd0;
    end else begin
      if (s1_ld) s1_valid <= s_valid;
      if (s2_ld) begin
        m_valid <= s1_valid;
        m_eol <= s1_valid && s1_eol;
        m_eof <= s1_valid && s1_eof;
      end
      if (s2_ld && s1_valid) m_data <= s1_mode == 2'd2 ? s1_rgb : {y, y, y};
      if (in_xfer) begin
        col <= eol ? '0 : col + CW'(1);
        row <= eol ? (eof ? '0 : row + RW'(1)) : row;
        mode_q <= cur_mode;
      end
    end
  end
  // Stage-1 payload needs no reset: it is only consumed while s1_valid is set.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_sum <= (DW+2)'(r) + (DW+2)'(g) + (DW+2)'(b);
      s1_luma <= (DW+8)'(r) * (DW+8)'(77) + (DW+8)'(g) * (DW+8)'(150) + (DW+8)'(b) * (DW+8)'(29);
      s1_rgb <= s_data;
      s1_mode <= cur_mode;
      s1_eol <= eol;
      s1_eof <= eof;
    end
  end
`ifdef GRAY_STATS_EN
  localparam int SW = DW + $clog2(IMG_W * IMG_H);
  logic [SW-1:0] acc;
  // The G channel equals Y in the grey modes and is the passthrough statistic.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      frame_sum <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= m_valid && m_ready && m_eof;
      if (m_valid && m_ready) begin
        acc <= m_eof ? '0 : acc + SW'(m_data[DW +: DW]);
        if (m_eof) frame_sum <= acc + SW'(m_data[DW +: DW]);
      end
    end
  end
`else
  assign frame_sum = '0;
  assign frame_done = 1'b0;
`endif
endmodule
